// File: rtl/alu_md.sv
// alu_md: multi-cycle ALU; shift-add MUL/MULH, restoring DIVU/REMU only when ALU_MD_DIV_EN is defined.
// Latency 1 (logic/add/shift), WIDTH+1 (iterative ops); one op in flight, result held until out_ready.
module alu_md #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] in_0,
  input  logic [WIDTH-1:0] in_1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             of,
  output logic             dz
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_XOR  = 4'd2;
  localparam logic [3:0] OP_ADDS = 4'd3;
  localparam logic [3:0] OP_ADDU = 4'd4;
  localparam logic [3:0] OP_SUBS = 4'd5;
  localparam logic [3:0] OP_SUBU = 4'd6;
  localparam logic [3:0] OP_SHRL = 4'd7;
  localparam logic [3:0] OP_SHLL = 4'd8;
  localparam logic [3:0] OP_SHRA = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;
  localparam logic [3:0] OP_MULH = 4'd11;
  localparam logic [3:0] OP_DIVU = 4'd12;
  localparam logic [3:0] OP_REMU = 4'd13;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q, state_d;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] opnd_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic [CW-1:0]    cnt_q;

  logic             accept, is_mul, go_calc, last_step;
  logic [WIDTH-1:0] add_res, sub_res;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] quick_out;
  logic             quick_of, quick_dz;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] step_hi, step_lo, calc_res;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign accept    = in_valid && in_ready;

  assign add_res = in_0 + in_1;
  assign sub_res = in_0 - in_1;
  assign shamt   = in_1[SHW-1:0];
  assign is_mul  = (op == OP_MUL) || (op == OP_MULH);

`ifdef ALU_MD_DIV_EN
  // Divide by zero is resolved in one cycle; only real divides iterate.
  assign go_calc = is_mul || (((op == OP_DIVU) || (op == OP_REMU)) && (in_1 != '0));
`else
  assign go_calc = is_mul;
`endif

  always_comb begin
    quick_out = in_0;
    quick_of  = 1'b0;
    quick_dz  = 1'b0;
    case (op)
      OP_AND:  quick_out = in_0 & in_1;
      OP_OR:   quick_out = in_0 | in_1;
      OP_XOR:  quick_out = in_0 ^ in_1;
      OP_ADDS: begin
        quick_out = add_res;
        quick_of  = (in_0[WIDTH-1] == in_1[WIDTH-1]) && (add_res[WIDTH-1] != in_0[WIDTH-1]);
      end
      OP_ADDU: quick_out = add_res;
      OP_SUBS: begin
        quick_out = sub_res;
        quick_of  = (in_0[WIDTH-1] != in_1[WIDTH-1]) && (sub_res[WIDTH-1] != in_0[WIDTH-1]);
      end
      OP_SUBU: quick_out = sub_res;
      OP_SHRL: quick_out = in_0 >> shamt;
      OP_SHLL: quick_out = in_0 << shamt;
      OP_SHRA: quick_out = $unsigned($signed(in_0) >>> shamt);
      OP_MUL, OP_MULH: quick_out = '0;
`ifdef ALU_MD_DIV_EN
      OP_DIVU: begin
        quick_out = '1;
        quick_dz  = (in_1 == '0);
      end
      OP_REMU: begin
        quick_out = in_0;
        quick_dz  = (in_1 == '0);
      end
`else
      OP_DIVU, OP_REMU: quick_out = '0;
`endif
      default: quick_out = in_0;
    endcase
  end

  // Multiply: hi accumulates, lo holds the multiplier and shifts in product bits.
  assign mul_sum = {1'b0, hi_q} + {1'b0, opnd_q & {WIDTH{lo_q[0]}}};

`ifdef ALU_MD_DIV_EN
  // Divide: hi is the partial remainder, lo shifts dividend out and quotient in.
  logic [WIDTH:0] div_shift, div_trial;
  assign div_shift = {hi_q, lo_q[WIDTH-1]};
  assign div_trial = div_shift - {1'b0, opnd_q};
`endif

  always_comb begin
    step_hi = mul_sum[WIDTH:1];
    step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
`ifdef ALU_MD_DIV_EN
    if ((op_q == OP_DIVU) || (op_q == OP_REMU)) begin
      step_hi = div_trial[WIDTH] ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0];
      step_lo = {lo_q[WIDTH-2:0], ~div_trial[WIDTH]};
    end
`endif
  end

  assign calc_res  = ((op_q == OP_MULH) || (op_q == OP_REMU)) ? step_hi : step_lo;
  assign last_step = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = go_calc ? CALC : DONE;
      CALC:    if (last_step) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q   <= '0;
      opnd_q <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      cnt_q  <= '0;
      out    <= '0;
      of     <= 1'b0;
      dz     <= 1'b0;
    end else if (accept) begin
      op_q   <= op;
      opnd_q <= is_mul ? in_0 : in_1;
      hi_q   <= '0;
      lo_q   <= is_mul ? in_1 : in_0;
      cnt_q  <= '0;
      if (!go_calc) begin
        out <= quick_out;
        of  <= quick_of;
        dz  <= quick_dz;
      end
    end else if (state_q == CALC) begin
      hi_q  <= step_hi;
      lo_q  <= step_lo;
      cnt_q <= cnt_q + CW'(1);
      if (last_step) begin
        cnt_q <= '0;
        out   <= calc_res;
        of    <= 1'b0;
        dz    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_md.sv
// tb_alu_md: directed plus random operations against an arithmetic reference model.
module tb_alu_md;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op_r;
  logic [31:0] in_0, in_1;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] dut_out;
  logic        of, dz;

  int checks = 0;
  int errors = 0;

  alu_md #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op(op_r), .in_0(in_0), .in_1(in_1), .out_valid(out_valid),
    .out_ready(out_ready), .out(dut_out), .of(of), .dz(dz)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: results from plain integer arithmetic on wide values.
  function automatic void model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic f, output logic z,
                                output int lat);
    longint sa, sb, t;
    logic [63:0] p;
    logic [4:0]  sh;
    sa  = $signed(a);
    sb  = $signed(b);
    p   = {32'd0, a} * {32'd0, b};
    sh  = b[4:0];
    r   = a;
    f   = 1'b0;
    z   = 1'b0;
    lat = 1;
    case (o)
      4'd0: r = a & b;
      4'd1: r = a | b;
      4'd2: r = a ^ b;
      4'd3: begin t = sa + sb; r = a + b; f = (t != longint'($signed(r))); end
      4'd4: r = a + b;
      4'd5: begin t = sa - sb; r = a - b; f = (t != longint'($signed(r))); end
      4'd6: r = a - b;
      4'd7: r = a >> sh;
      4'd8: r = a << sh;
      4'd9: r = $unsigned($signed(a) >>> sh);
      4'd10: begin r = p[31:0];  lat = 33; end
      4'd11: begin r = p[63:32]; lat = 33; end
      4'd12, 4'd13: begin
`ifdef ALU_MD_DIV_EN
        if (b == 32'd0) begin
          r = (o == 4'd12) ? 32'hFFFF_FFFF : a;
          z = 1'b1;
        end else begin
          r   = (o == 4'd12) ? a / b : a % b;
          lat = 33;
        end
`else
        r = 32'd0;
`endif
      end
      default: r = a;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      4:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Entered and left just after a falling edge with the DUT idle.
  task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int hold, output logic [31:0] r_out, output logic r_of,
                        output logic r_dz, output int r_lat);
    logic [31:0] e_out;
    logic        e_of, e_dz;
    int          e_lat;
    bit          busy_ok, hold_ok;
    model(o, a, b, e_out, e_of, e_dz, e_lat);
    check($sformatf("in_ready idle op%0d", o), in_ready, 1);
    in_valid = 1'b1; op_r = o; in_0 = a; in_1 = b;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; op_r = 4'($urandom); in_0 = $urandom; in_1 = $urandom;
    r_lat   = 1;
    busy_ok = 1'b1;
    while (!out_valid && r_lat < 100) begin
      if (in_ready) busy_ok = 1'b0;
      @(negedge clk);
      r_lat++;
    end
    r_out = dut_out; r_of = of; r_dz = dz;
    check($sformatf("latency op%0d", o), r_lat, e_lat);
    check($sformatf("out op%0d a=%0h b=%0h", o, a, b), r_out, e_out);
    check($sformatf("of op%0d a=%0h b=%0h", o, a, b), r_of, e_of);
    check($sformatf("dz op%0d b=%0h", o, b), r_dz, e_dz);
    check($sformatf("in_ready low while busy op%0d", o), busy_ok, 1);
    if (hold > 0) begin
      hold_ok = 1'b1;
      for (int i = 0; i < hold; i++) begin
        in_valid = 1'($urandom); op_r = 4'($urandom); in_0 = $urandom; in_1 = $urandom;
        @(negedge clk);
        if (!out_valid || in_ready || dut_out !== r_out || of !== r_of || dz !== r_dz)
          hold_ok = 1'b0;
      end
      check($sformatf("hold stable %0d cycles", hold), hold_ok, 1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("out_valid drops after out_ready", out_valid, 0);
    check("in_ready after out_ready", in_ready, 1);
  endtask

  initial begin
    logic [31:0] ro, a, b;
    logic        rf, rz;
    logic [3:0]  o;
    int          rl;
    bit          stale_ok;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    op_r = 4'd0; in_0 = 32'd0; in_1 = 32'd0;
    repeat (2) @(negedge clk);
    check("reset in_ready", in_ready, 1);
    check("reset out_valid", out_valid, 0);
    check("reset out", dut_out, 0);
    check("reset of", of, 0);
    check("reset dz", dz, 0);
    reset = 1'b0;

    run_op(4'd3, 32'h7FFF_FFFF, 32'h1, 0, ro, rf, rz, rl);
    check("adds max+1 out", ro, 32'h8000_0000);
    check("adds max+1 of", rf, 1);
    check("adds first accept latency", rl, 1);
    run_op(4'd4, 32'h7FFF_FFFF, 32'h1, 0, ro, rf, rz, rl);
    check("addu max+1 of", rf, 0);

    run_op(4'd9, 32'h8000_0000, 32'h0000_0104, 0, ro, rf, rz, rl);
    check("shra low bits only", ro, 32'hF800_0000);
    run_op(4'd7, 32'h8000_0000, 32'h0000_0104, 0, ro, rf, rz, rl);
    check("shrl low bits only", ro, 32'h0800_0000);
    run_op(4'd8, 32'h1234_5678, 32'hFFFF_FFE0, 0, ro, rf, rz, rl);
    check("shll by 0", ro, 32'h1234_5678);

    run_op(4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, ro, rf, rz, rl);
    check("mulh all ones", ro, 32'hFFFF_FFFE);
    check("mulh latency", rl, 33);
    run_op(4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, ro, rf, rz, rl);
    check("mul all ones", ro, 32'h0000_0001);
    run_op(4'd10, 32'd0, 32'h1234_5678, 0, ro, rf, rz, rl);
    check("mul by zero latency", rl, 33);

    run_op(4'd12, 32'd100, 32'd7, 0, ro, rf, rz, rl);
`ifdef ALU_MD_DIV_EN
    check("divu 100/7", ro, 32'd14);
    check("divu latency", rl, 33);
`else
    check("divu disabled out", ro, 32'd0);
    check("divu disabled latency", rl, 1);
`endif
    run_op(4'd13, 32'd100, 32'd7, 0, ro, rf, rz, rl);
`ifdef ALU_MD_DIV_EN
    check("remu 100%7", ro, 32'd2);
`else
    check("remu disabled out", ro, 32'd0);
`endif
    run_op(4'd12, 32'd5, 32'd0, 0, ro, rf, rz, rl);
`ifdef ALU_MD_DIV_EN
    check("divu by zero out", ro, 32'hFFFF_FFFF);
    check("divu by zero dz", rz, 1);
`else
    check("divu by zero disabled out", ro, 32'd0);
    check("divu by zero disabled dz", rz, 0);
`endif
    check("divu by zero latency", rl, 1);

    run_op(4'd5, 32'h8000_0000, 32'h1, 10, ro, rf, rz, rl);
    check("subs min-1 of", rf, 1);

    // Abort a multiply partway through.
    in_valid = 1'b1; op_r = 4'd10; in_0 = 32'hDEAD_BEEF; in_1 = 32'h1234_5678;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort out_valid", out_valid, 0);
    check("abort in_ready", in_ready, 1);
    check("abort out cleared", dut_out, 0);
    @(negedge clk);
    reset = 1'b0;
    stale_ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) stale_ok = 1'b0;
    end
    check("no stale result after abort", stale_ok, 1);

    for (int n = 0; n < 150; n++) begin
      o = 4'($urandom);
      a = pick();
      b = pick();
      run_op(o, a, b, $urandom_range(0, 3), ro, rf, rz, rl);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
